// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier family.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_MAX_WIDTH = 16;

endpackage

// File: rtl/multiplicador_sign_adj.sv
// Conditional two's-complement negate; used as abs() on operands and as the
// final sign fix-up on the product.
module multiplicador_sign_adj #(
  parameter int W = 4
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/multiplicador_seq_n.sv
// Sequential shift-add multiplier with start/busy/done handshake and
// run-time signed/unsigned mode; magnitude multiply, sign applied at the end.
module multiplicador_seq_n
  import mult_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   A_i,
  input  logic [WIDTH-1:0]   B_i,
  output logic [2*WIDTH-1:0] Y_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [1:0]         fsm_state_o
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_CALC = 2'(CALC);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = (WIDTH > 1 && WIDTH <= MULT_MAX_WIDTH) ? $clog2(WIDTH) : 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             neg_q,    neg_d;
  logic [PW-1:0]    y_q,      y_d;
  logic             done_q,   done_d;

  logic             mode_eff;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [PW-1:0]    prod_adj;

  assign mode_eff = signed_i & SIGNED_EN;

  multiplicador_sign_adj #(.W(WIDTH)) u_abs_a (
    .val_i (A_i),
    .neg_i (mode_eff & A_i[WIDTH-1]),
    .val_o (abs_a)
  );

  multiplicador_sign_adj #(.W(WIDTH)) u_abs_b (
    .val_i (B_i),
    .neg_i (mode_eff & B_i[WIDTH-1]),
    .val_o (abs_b)
  );

  multiplicador_sign_adj #(.W(PW)) u_neg_y (
    .val_i (acc_q),
    .neg_i (neg_q),
    .val_o (prod_adj)
  );

  // Handshake: start_i is only looked at in IDLE (operands and signed_i are
  // captured on that same edge); busy_o covers CALC and DONE, and done_o is a
  // single-cycle pulse coincident with the Y_o update. No request queuing.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    y_d      = y_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mcand_d  = abs_a;
          mplier_d = abs_b;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = mode_eff & (A_i[WIDTH-1] ^ B_i[WIDTH-1]);
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
        end
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        y_d     = prod_adj;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      y_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      y_q      <= y_d;
      done_q   <= done_d;
    end
  end

  assign Y_o         = y_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q == ST_CALC) || (state_q == ST_DONE);
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_multiplicador_seq_n.sv
// Directed bench for multiplicador_seq_n: three instances cover signed 4-bit,
// unsigned-only 4-bit and signed 8-bit configurations.
module tb_multiplicador_seq_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // WIDTH=4, SIGNED_EN=1
  logic       rst4 = 1'b1, start4 = 1'b0, sg4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] y4;
  logic       busy4, done4;
  logic [1:0] st4;

  // WIDTH=4, SIGNED_EN=0
  logic       rst4u = 1'b1, start4u = 1'b0, sg4u = 1'b0;
  logic [3:0] a4u = '0, b4u = '0;
  logic [7:0] y4u;
  logic       busy4u, done4u;
  logic [1:0] st4u;

  // WIDTH=8, SIGNED_EN=1
  logic        rst8 = 1'b1, start8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] y8;
  logic        busy8, done8;
  logic [1:0]  st8;

  multiplicador_seq_n #(.WIDTH(4), .SIGNED_EN(1'b1)) u_dut4 (
    .clk_i(clk), .rst_i(rst4), .start_i(start4), .signed_i(sg4),
    .A_i(a4), .B_i(b4), .Y_o(y4), .busy_o(busy4), .done_o(done4),
    .fsm_state_o(st4)
  );

  multiplicador_seq_n #(.WIDTH(4), .SIGNED_EN(1'b0)) u_dut4u (
    .clk_i(clk), .rst_i(rst4u), .start_i(start4u), .signed_i(sg4u),
    .A_i(a4u), .B_i(b4u), .Y_o(y4u), .busy_o(busy4u), .done_o(done4u),
    .fsm_state_o(st4u)
  );

  multiplicador_seq_n #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut8 (
    .clk_i(clk), .rst_i(rst8), .start_i(start8), .signed_i(sg8),
    .A_i(a8), .B_i(b8), .Y_o(y8), .busy_o(busy8), .done_o(done8),
    .fsm_state_o(st8)
  );

  // Driver: one-cycle start on the 4-bit signed instance, waits (bounded) for done.
  // lat is the index of the done sample, 0 being the sample right after the start edge.
  task automatic run_op4(input logic s, input logic [3:0] a, input logic [3:0] b,
                         output logic [7:0] y, output int lat);
    lat = -1;
    y   = '0;
    @(negedge clk); start4 = 1'b1; sg4 = s; a4 = a; b4 = b;
    @(negedge clk); start4 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done4) begin
        lat = i;
        y   = y4;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op4u(input logic s, input logic [3:0] a, input logic [3:0] b,
                          output logic [7:0] y, output int lat);
    lat = -1;
    y   = '0;
    @(negedge clk); start4u = 1'b1; sg4u = s; a4u = a; b4u = b;
    @(negedge clk); start4u = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done4u) begin
        lat = i;
        y   = y4u;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst4 = 1'b1; rst4u = 1'b1; rst8 = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({st4, y4, busy4, done4} !== 12'h000) begin
      errors++;
      $display("FAIL reset_w4: state=%0d y=%0d busy=%0b done=%0b expected all 0", st4, y4, busy4, done4);
    end
    checks++;
    if ({st4u, y4u, busy4u, done4u} !== 12'h000) begin
      errors++;
      $display("FAIL reset_w4u: state=%0d y=%0d busy=%0b done=%0b expected all 0", st4u, y4u, busy4u, done4u);
    end
    checks++;
    if ({st8, y8, busy8, done8} !== 20'h00000) begin
      errors++;
      $display("FAIL reset_w8: state=%0d y=%0d busy=%0b done=%0b expected all 0", st8, y8, busy8, done8);
    end
    rst4 = 1'b0; rst4u = 1'b0; rst8 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned_max();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_idx = -1;
    logic [7:0] y_at_done = '0;
    logic [1:0] st_calc = '0;
    logic [1:0] st_done = '0;
    @(negedge clk); start4 = 1'b1; sg4 = 1'b0; a4 = 4'd15; b4 = 4'd15;
    @(negedge clk); start4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy4) busy_cnt++;
      if (i == 0) st_calc = st4;
      if (i == 4) st_done = st4;
      if (done4) begin
        done_cnt++;
        if (done_idx < 0) begin
          done_idx  = i;
          y_at_done = y4;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (y_at_done !== 8'd225) begin
      errors++;
      $display("FAIL umax_y: got %0d expected 225", y_at_done);
    end
    checks++;
    if (done_idx != 5) begin
      errors++;
      $display("FAIL umax_latency: done at sample %0d expected 5", done_idx);
    end
    checks++;
    if (busy_cnt != 5) begin
      errors++;
      $display("FAIL umax_busy_cycles: got %0d expected 5", busy_cnt);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL umax_done_count: got %0d expected 1", done_cnt);
    end
    checks++;
    if (st_calc !== 2'd1 || st_done !== 2'd2) begin
      errors++;
      $display("FAIL umax_fsm_state: calc=%0d done=%0d expected 1 and 2", st_calc, st_done);
    end
  endtask

  task automatic test_signed();
    logic [7:0] y;
    int lat;
    run_op4(1'b1, 4'b1101, 4'd5, y, lat);
    checks++;
    if (y !== 8'hF1 || lat != 5) begin
      errors++;
      $display("FAIL signed_m3x5: got y=%h lat=%0d expected y=f1 lat=5", y, lat);
    end
    run_op4(1'b1, 4'b1000, 4'b1000, y, lat);
    checks++;
    if (y !== 8'h40 || lat != 5) begin
      errors++;
      $display("FAIL signed_m8xm8: got y=%h lat=%0d expected y=40 lat=5", y, lat);
    end
    run_op4(1'b1, 4'b1000, 4'd7, y, lat);
    checks++;
    if (y !== 8'hC8 || lat != 5) begin
      errors++;
      $display("FAIL signed_m8x7: got y=%h lat=%0d expected y=c8 lat=5", y, lat);
    end
    run_op4(1'b0, 4'b1101, 4'd5, y, lat);
    checks++;
    if (y !== 8'd65 || lat != 5) begin
      errors++;
      $display("FAIL unsigned_mode_13x5: got y=%0d lat=%0d expected y=65 lat=5", y, lat);
    end
  endtask

  task automatic test_signed_disabled();
    logic [7:0] y;
    int lat;
    run_op4u(1'b1, 4'hD, 4'd5, y, lat);
    checks++;
    if (y !== 8'd65 || lat != 5) begin
      errors++;
      $display("FAIL sgn_dis_13x5: got y=%0d lat=%0d expected y=65 lat=5", y, lat);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (y4u !== 8'd65 || done4u !== 1'b0) begin
      errors++;
      $display("FAIL sgn_dis_hold_idle: got y=%0d done=%0b expected y=65 done=0", y4u, done4u);
    end
    @(negedge clk); start4u = 1'b1; sg4u = 1'b1; a4u = 4'hF; b4u = 4'd3;
    @(negedge clk); start4u = 1'b0;
    @(negedge clk);
    checks++;
    if (y4u !== 8'd65 || busy4u !== 1'b1) begin
      errors++;
      $display("FAIL sgn_dis_hold_busy: got y=%0d busy=%0b expected y=65 busy=1", y4u, busy4u);
    end
    for (int i = 0; i < 20 && !done4u; i++) @(negedge clk);
    checks++;
    if (y4u !== 8'd45 || done4u !== 1'b1) begin
      errors++;
      $display("FAIL sgn_dis_15x3: got y=%0d done=%0b expected y=45 done=1", y4u, done4u);
    end
  endtask

  task automatic test_ignored_start();
    int done_cnt = 0;
    int done_idx = -1;
    logic [7:0] y_at_done = '0;
    @(negedge clk); start4 = 1'b1; sg4 = 1'b0; a4 = 4'd3; b4 = 4'd3;
    @(negedge clk); start4 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done4) begin
        done_cnt++;
        if (done_idx < 0) begin
          done_idx  = i;
          y_at_done = y4;
        end
      end
      @(negedge clk);
      if (i == 0) begin
        start4 = 1'b1; a4 = 4'd7; b4 = 4'd7;
      end else begin
        start4 = 1'b0;
      end
    end
    checks++;
    if (y_at_done !== 8'd9 || done_idx != 5) begin
      errors++;
      $display("FAIL busy_start_y: got y=%0d at sample %0d expected 9 at 5", y_at_done, done_idx);
    end
    checks++;
    if (done_cnt != 1 || y4 !== 8'd9) begin
      errors++;
      $display("FAIL busy_start_ignored: dones=%0d y=%0d expected 1 and 9", done_cnt, y4);
    end
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0;
    @(negedge clk); start4 = 1'b1; sg4 = 1'b0; a4 = 4'd15; b4 = 4'd15;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk); rst4 = 1'b1;
    @(negedge clk);
    checks++;
    if (st4 !== 2'd0 || y4 !== 8'd0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: state=%0d y=%0d busy=%0b done=%0b expected all 0", st4, y4, busy4, done4);
    end
    rst4 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done4) done_cnt++;
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 0 || y4 !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_no_done: dones=%0d y=%0d expected 0 and 0", done_cnt, y4);
    end
  endtask

  task automatic test_back_to_back();
    int idx1 = -1;
    int idx2 = -1;
    logic [15:0] y1 = '0;
    logic [15:0] y2 = '0;
    logic busy_after = 1'b0;
    @(negedge clk); start8 = 1'b1; sg8 = 1'b0; a8 = 8'd200; b8 = 8'd200;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (idx1 >= 0 && i == idx1 + 1) busy_after = busy8;
      if (done8) begin
        if (idx1 < 0) begin
          idx1 = i; y1 = y8; a8 = 8'd255; b8 = 8'd255;
        end else if (idx2 < 0) begin
          idx2 = i; y2 = y8; start8 = 1'b0;
        end
      end
      if (idx2 >= 0) break;
      @(negedge clk);
    end
    start8 = 1'b0;
    checks++;
    if (y1 !== 16'd40000 || idx1 != 9) begin
      errors++;
      $display("FAIL b2b_first: got y=%0d at sample %0d expected 40000 at 9", y1, idx1);
    end
    checks++;
    if (y2 !== 16'd65025) begin
      errors++;
      $display("FAIL b2b_second: got y=%0d expected 65025", y2);
    end
    checks++;
    if (idx2 - idx1 != 10 || idx2 < 0) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles expected 10", idx2 - idx1);
    end
    checks++;
    if (busy_after !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: busy after first done=%0b expected 1", busy_after);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed();
    test_signed_disabled();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
